// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : ID/EX pipeline register for a LEGv8 5-stage pipeline.
//               Captures the decode-stage control bits, register read data,
//               immediate, PC and register numbers for the EX stage.
//               Handles stall, flush and load-use bubble insertion, and keeps
//               a saturating count of inserted bubbles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   LOAD_USE_DETECT_EN - when defined, load-use detection and bubble insertion
//                        are active and bubble_count counts. When undefined,
//                        the hazard term is tied to 0 (hazard_stall = 0,
//                        bubble_count = 0).
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   stall_in           hold every ID/EX register
//   flush_in           squash the instruction in ID (overrides stall_in)
//   id_*               decode-stage instruction fields and control bits
//   ex_*               registered copies of the id_* inputs
//   hazard_stall       combinational: freeze PC and IF/ID this cycle
//   bubble_count       bubbles inserted since reset, saturating
// ============================================================================
module id_ex_pipe_reg #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [10:0]       id_opcode,
  input  logic [4:0]        id_rn,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_branch,
  input  logic              id_uncondbranch,
  input  logic              id_aluop1,
  input  logic              id_aluop0,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [10:0]       ex_opcode,
  output logic [4:0]        ex_rn,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              ex_alusrc,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic              ex_uncondbranch,
  output logic              ex_aluop1,
  output logic              ex_aluop0,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam logic [4:0] C_XZR         = 5'd31;
  localparam int         C_CTRL_W      = 9;
  // Bit positions inside the packed control vector.
  localparam int         C_IDX_REGWR   = 6;
  localparam int         C_IDX_MEMRD   = 5;
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  // Control bits: {alusrc, memtoreg, regwrite, memread, memwrite,
  //                branch, uncondbranch, aluop1, aluop0}
  logic [C_CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   pc_q,    pc_d;
  logic [DATA_W-1:0]   rd1_q,   rd1_d;
  logic [DATA_W-1:0]   rd2_q,   rd2_d;
  logic [DATA_W-1:0]   imm_q,   imm_d;
  logic [10:0]         opc_q,   opc_d;
  logic [4:0]          rn_q,    rn_d;
  logic [4:0]          rs2_q,   rs2_d;
  logic [4:0]          rd_q,    rd_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;

  logic [C_CTRL_W-1:0] w_id_ctrl;
  logic                w_haz;
  logic                w_hold;

  assign w_id_ctrl = {id_alusrc, id_memtoreg, id_regwrite, id_memread,
                      id_memwrite, id_branch, id_uncondbranch,
                      id_aluop1, id_aluop0};

`ifdef LOAD_USE_DETECT_EN
  // A load in EX whose destination is read by the instruction in ID.
  // XZR is never a real destination, so it cannot create a hazard.
  assign w_haz = id_valid & valid_q & ctrl_q[C_IDX_MEMRD] & (rd_q != C_XZR) &
                 ((rd_q == id_rn) | (rd_q == id_rs2));
`else
  assign w_haz = 1'b0;
`endif

  // Still reports the hazard under stall_in so the front end stays frozen;
  // the hold itself wins over the bubble in the register update below.
  assign hazard_stall = w_haz & ~flush_in & ~reset;

  // Data fields hold only under a stall without flush; under flush or
  // bubble they are don't-care, so they simply load.
  assign w_hold = stall_in & ~flush_in;

  always_comb begin
    pc_d    = w_hold ? pc_q  : id_pc;
    rd1_d   = w_hold ? rd1_q : id_rd1;
    rd2_d   = w_hold ? rd2_q : id_rd2;
    imm_d   = w_hold ? imm_q : id_imm;
    opc_d   = w_hold ? opc_q : id_opcode;
    rn_d    = w_hold ? rn_q  : id_rn;
    rs2_d   = w_hold ? rs2_q : id_rs2;
    rd_d    = w_hold ? rd_q  : id_rd;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;

    if (flush_in) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (stall_in) begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
    end else if (w_haz) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (cnt_q != C_CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      valid_d = id_valid;
      ctrl_d  = id_valid ? w_id_ctrl : '0;
      // Writes to XZR are discarded at the source.
      if (id_rd == C_XZR) begin
        ctrl_d[C_IDX_REGWR] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      opc_q   <= '0;
      rn_q    <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      opc_q   <= opc_d;
      rn_q    <= rn_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid        = valid_q;
  assign ex_pc           = pc_q;
  assign ex_rd1          = rd1_q;
  assign ex_rd2          = rd2_q;
  assign ex_imm          = imm_q;
  assign ex_opcode       = opc_q;
  assign ex_rn           = rn_q;
  assign ex_rs2          = rs2_q;
  assign ex_rd           = rd_q;
  assign ex_alusrc       = ctrl_q[8];
  assign ex_memtoreg     = ctrl_q[7];
  assign ex_regwrite     = ctrl_q[6];
  assign ex_memread      = ctrl_q[5];
  assign ex_memwrite     = ctrl_q[4];
  assign ex_branch       = ctrl_q[3];
  assign ex_uncondbranch = ctrl_q[2];
  assign ex_aluop1       = ctrl_q[1];
  assign ex_aluop0       = ctrl_q[0];
  assign bubble_count    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipe_reg
// Description : Directed self-checking bench for id_ex_pipe_reg (CNT_W = 4).
//               Expectations follow LOAD_USE_DETECT_EN as seen by this file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;

`ifdef LOAD_USE_DETECT_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;

  // Control encodings {alusrc,memtoreg,regwrite,memread,memwrite,branch,uncond,aluop1,aluop0}
  localparam logic [8:0] C_ADD  = 9'b001000010;
  localparam logic [8:0] C_LDUR = 9'b111100000;
  localparam logic [8:0] C_CBR  = 9'b000011000;

  logic clk = 1'b0;
  logic reset, stall_in, flush_in, id_valid;
  logic [DATA_W-1:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [10:0] id_opcode;
  logic [4:0]  id_rn, id_rs2, id_rd;
  logic [8:0]  id_ctrl;
  logic ex_valid;
  logic [DATA_W-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [10:0] ex_opcode;
  logic [4:0]  ex_rn, ex_rs2, ex_rd;
  logic ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite;
  logic ex_branch, ex_uncondbranch, ex_aluop1, ex_aluop0;
  logic hazard_stall;
  logic [CNT_W-1:0] bubble_count;
  logic [8:0] ex_ctrl;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  assign ex_ctrl = {ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
                    ex_branch, ex_uncondbranch, ex_aluop1, ex_aluop0};

  id_ex_pipe_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_opcode(id_opcode), .id_rn(id_rn), .id_rs2(id_rs2),
    .id_rd(id_rd),
    .id_alusrc(id_ctrl[8]), .id_memtoreg(id_ctrl[7]), .id_regwrite(id_ctrl[6]),
    .id_memread(id_ctrl[5]), .id_memwrite(id_ctrl[4]), .id_branch(id_ctrl[3]),
    .id_uncondbranch(id_ctrl[2]), .id_aluop1(id_ctrl[1]), .id_aluop0(id_ctrl[0]),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_opcode(ex_opcode), .ex_rn(ex_rn), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd),
    .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_uncondbranch(ex_uncondbranch), .ex_aluop1(ex_aluop1), .ex_aluop0(ex_aluop0),
    .hazard_stall(hazard_stall), .bubble_count(bubble_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Data fields are derived from the PC so each instruction is distinguishable.
  task automatic drive(input logic v, input logic [63:0] pc, input logic [4:0] rn,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [8:0] ctrl);
    id_valid  = v;
    id_pc     = pc;
    id_rd1    = ~pc;
    id_rd2    = pc ^ 64'h5555_5555_5555_5555;
    id_imm    = {pc[31:0], pc[63:32]};
    id_opcode = pc[10:0];
    id_rn     = rn;
    id_rs2    = rs2;
    id_rd     = rd;
    id_ctrl   = ctrl;
    #1;
  endtask

  task automatic bump_cnt;
    if (HZ_EN && exp_cnt < 15) exp_cnt++;
  endtask

  initial begin
    reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    drive(1'b1, {$urandom, $urandom}, 5'($urandom), 5'($urandom), 5'($urandom), 9'h1FF);

    // 1: reset with random inputs
    tick;
    drive(1'b1, {$urandom, $urandom}, 5'($urandom), 5'($urandom), 5'($urandom), 9'h1FF);
    tick;
    check_eq("rst_valid", 64'(ex_valid), 64'd0);
    check_eq("rst_ctrl",  64'(ex_ctrl), 64'd0);
    check_eq("rst_pc",    ex_pc, 64'd0);
    check_eq("rst_rd",    64'(ex_rd), 64'd0);
    check_eq("rst_cnt",   64'(bubble_count), 64'd0);
    check_eq("rst_hzs",   64'(hazard_stall), 64'd0);
    reset = 1'b0;

    // 2: ADD X3 then the next instruction
    drive(1'b1, 64'h100, 5'd1, 5'd2, 5'd3, C_ADD);
    tick;
    check_eq("add_rd",    64'(ex_rd), 64'd3);
    check_eq("add_rw",    64'(ex_regwrite), 64'd1);
    check_eq("add_pc",    ex_pc, 64'h100);
    check_eq("add_rd1",   ex_rd1, ~64'h100);
    check_eq("add_valid", 64'(ex_valid), 64'd1);
    drive(1'b1, 64'h104, 5'd1, 5'd2, 5'd4, C_ADD);
    tick;
    check_eq("nxt_pc",    ex_pc, 64'h104);
    check_eq("nxt_rd",    64'(ex_rd), 64'd4);

    // 3: LDUR X5 followed by a reader of X5
    drive(1'b1, 64'h108, 5'd2, 5'd3, 5'd5, C_LDUR);
    tick;
    check_eq("ld_memrd",  64'(ex_memread), 64'd1);
    drive(1'b1, 64'h10C, 5'd5, 5'd2, 5'd6, C_ADD);
    check_eq("lu_hzs",    64'(hazard_stall), 64'(HZ_EN));
    tick;
    bump_cnt;
    check_eq("lu_valid",  64'(ex_valid), HZ_EN ? 64'd0 : 64'd1);
    check_eq("lu_ctrl",   64'(ex_ctrl), HZ_EN ? 64'd0 : 64'(C_ADD));
    check_eq("lu_cnt",    64'(bubble_count), 64'(exp_cnt));
    check_eq("lu_hzs2",   64'(hazard_stall), 64'd0);
    tick;
    check_eq("dep_valid", 64'(ex_valid), 64'd1);
    check_eq("dep_rd",    64'(ex_rd), 64'd6);
    check_eq("dep_rw",    64'(ex_regwrite), 64'd1);

    // 4: LDUR X31 and a reader of X31; ADD to X31
    drive(1'b1, 64'h110, 5'd1, 5'd2, 5'd31, C_LDUR);
    tick;
    check_eq("ldz_ctrl",  64'(ex_ctrl), 64'(9'b110100000));
    drive(1'b1, 64'h114, 5'd31, 5'd31, 5'd7, C_ADD);
    check_eq("ldz_hzs",   64'(hazard_stall), 64'd0);
    tick;
    check_eq("ldz_valid", 64'(ex_valid), 64'd1);
    check_eq("ldz_rd",    64'(ex_rd), 64'd7);
    check_eq("ldz_cnt",   64'(bubble_count), 64'(exp_cnt));
    drive(1'b1, 64'h118, 5'd1, 5'd2, 5'd31, C_ADD);
    tick;
    check_eq("xzr_rw",    64'(ex_regwrite), 64'd0);
    check_eq("xzr_ctrl",  64'(ex_ctrl), 64'(9'b000000010));

    // 5: flush + stall + live hazard
    drive(1'b1, 64'h120, 5'd1, 5'd2, 5'd7, C_LDUR);
    tick;
    flush_in = 1'b1; stall_in = 1'b1;
    drive(1'b1, 64'h124, 5'd7, 5'd1, 5'd8, C_CBR);
    check_eq("fl_hzs",    64'(hazard_stall), 64'd0);
    tick;
    check_eq("fl_valid",  64'(ex_valid), 64'd0);
    check_eq("fl_memwr",  64'(ex_memwrite), 64'd0);
    check_eq("fl_br",     64'(ex_branch), 64'd0);
    check_eq("fl_ctrl",   64'(ex_ctrl), 64'd0);
    check_eq("fl_cnt",    64'(bubble_count), 64'(exp_cnt));
    flush_in = 1'b0; stall_in = 1'b0;

    // 6a: stall for 3 cycles with changing inputs
    drive(1'b1, 64'h200, 5'd1, 5'd2, 5'd9, C_ADD);
    tick;
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h300 + 64'(i * 4), 5'(i), 5'(i + 1), 5'(10 + i), C_LDUR);
      tick;
      check_eq("st_pc",   ex_pc, 64'h200);
      check_eq("st_rd",   64'(ex_rd), 64'd9);
      check_eq("st_ctrl", 64'(ex_ctrl), 64'(C_ADD));
    end
    stall_in = 1'b0;

    // 6b: stall over a live hazard holds, then the bubble follows
    drive(1'b1, 64'h400, 5'd1, 5'd2, 5'd5, C_LDUR);
    tick;
    stall_in = 1'b1;
    drive(1'b1, 64'h404, 5'd3, 5'd5, 5'd6, C_ADD);
    check_eq("sh_hzs",    64'(hazard_stall), 64'(HZ_EN));
    tick;
    check_eq("sh_pc",     ex_pc, 64'h400);
    check_eq("sh_memrd",  64'(ex_memread), 64'd1);
    check_eq("sh_cnt",    64'(bubble_count), 64'(exp_cnt));
    stall_in = 1'b0;
    tick;
    bump_cnt;
    check_eq("sb_cnt",    64'(bubble_count), 64'(exp_cnt));

    // 6c: 2^CNT_W + 2 load-use pairs saturate the counter
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 64'h500, 5'd1, 5'd2, 5'd5, C_LDUR);
      tick;
      drive(1'b1, 64'h504, 5'd5, 5'd2, 5'd6, C_ADD);
      tick;
    end
    check_eq("sat_cnt",   64'(bubble_count), HZ_EN ? 64'd15 : 64'd0);

    // reset asserted mid-stall with a live hazard clears everything
    drive(1'b1, 64'h600, 5'd1, 5'd2, 5'd5, C_LDUR);
    tick;
    stall_in = 1'b1; reset = 1'b1;
    drive(1'b1, 64'h604, 5'd5, 5'd2, 5'd6, C_ADD);
    check_eq("rs_hzs",    64'(hazard_stall), 64'd0);
    tick;
    check_eq("rs_valid",  64'(ex_valid), 64'd0);
    check_eq("rs_ctrl",   64'(ex_ctrl), 64'd0);
    check_eq("rs_pc",     ex_pc, 64'd0);
    check_eq("rs_cnt",    64'(bubble_count), 64'd0);
    reset = 1'b0; stall_in = 1'b0;
    #1;
    check_eq("rs_hzs2",   64'(hazard_stall), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
